// File: rtl/datapath_control_unit.sv
// Hardwired fetch/execute sequencer for Datapath2: one control step per clk.
// Ports: clk, clr (async high), IR, CON_FF, Stop in; bus-out, reg-in,
// Gra/Grb/Grc, Read/Write, ALU_Control, Run out.
// Optional: CONTROL_ILLEGAL_TRAP_EN adds Illegal and traps ops 10000..11111.
module datapath_control_unit #(
    parameter logic [4:0] ALU_ADD = 5'd2,
    parameter logic [4:0] ALU_INC = 5'd12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        CONin,
    output logic        OutportIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  ALU_Control,
`ifdef CONTROL_ILLEGAL_TRAP_EN
    output logic        Illegal,
`endif
    output logic        Run
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    logic [3:0] state, nxt, last_st;
    logic [4:0] op;
    logic       is_ld, is_ldi, is_st, is_r, is_imm;
    logic       is_br, is_out, halt_op;
    logic [4:0] imm_alu;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign is_ld  = (op == 5'd0);
    assign is_ldi = (op == 5'd1);
    assign is_st  = (op == 5'd2);
    assign is_r   = (op >= 5'd3) && (op <= 5'd8);
    assign is_imm = (op >= 5'd9) && (op <= 5'd11);
    assign is_br  = (op == 5'd12);
    assign is_out = (op == 5'd13);

`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic is_ill;
    assign is_ill  = op[4];
    assign halt_op = (op == 5'd15) || is_ill;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            Illegal <= 1'b0;
        else if (state == S_T2 && is_ill)
            Illegal <= 1'b1;
    end
`else
    assign halt_op = (op == 5'd15);
`endif

    always_comb begin
        unique case (op)
            5'd10:   imm_alu = 5'b00101;
            5'd11:   imm_alu = 5'b00110;
            default: imm_alu = ALU_ADD;
        endcase
    end

    // Final control step of each opcode; nop and unknowns end at fetch.
    always_comb begin
        unique case (1'b1)
            is_ld, is_st:          last_st = S_T7;
            is_ldi, is_r, is_imm:  last_st = S_T5;
            is_br:                 last_st = S_T6;
            is_out:                last_st = S_T3;
            default:               last_st = S_T2;
        endcase
    end

    // Stop is only honoured where the machine would otherwise enter T0.
    always_comb begin
        case (state)
            S_RST:   nxt = Stop ? S_HALT : S_T0;
            S_HALT:  nxt = S_HALT;
            default: begin
                if (state == S_T2 && halt_op)
                    nxt = S_HALT;
                else if (state == last_st)
                    nxt = Stop ? S_HALT : S_T0;
                else
                    nxt = state + 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= S_RST;
        else
            state <= nxt;
    end

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        Rin = 1'b0; CONin = 1'b0; OutportIn = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Read = 1'b0; Write = 1'b0;
        ALU_Control = 5'd0;
        Run = (state >= S_T0) && (state <= S_T7);
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; Zin = 1'b1;
                ALU_Control = ALU_INC;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1;
                Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                unique case (1'b1)
                    is_ld, is_ldi, is_st: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    is_r, is_imm: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    is_br: begin
                        Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                    end
                    is_out: begin
                        Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (1'b1)
                    is_ld, is_ldi, is_st: begin
                        Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_ADD;
                    end
                    is_r: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        ALU_Control = op;
                    end
                    is_imm: begin
                        Cout = 1'b1; Zin = 1'b1; ALU_Control = imm_alu;
                    end
                    is_br: begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (1'b1)
                    is_ld, is_st: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    is_ldi, is_r, is_imm: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    is_br: begin
                        Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                unique case (1'b1)
                    is_ld: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    // MDRin with Read low captures the register from the bus.
                    is_st: begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end
                    is_br: begin
                        Zlowout = CON_FF; PCin = CON_FF;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                unique case (1'b1)
                    is_ld: begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    is_st: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Scoreboard bench for datapath_control_unit: directed instruction vectors.
// Stimulus queues expected per-cycle controls; a negedge monitor compares.
module tb_datapath_control_unit;

    typedef logic [26:0] vec_t;
    typedef struct {
        vec_t  v;
        string tag;
    } ent_t;

    localparam vec_t PCOUT  = 27'(1) << 0;
    localparam vec_t ZLOW   = 27'(1) << 1;
    localparam vec_t MDROUT = 27'(1) << 2;
    localparam vec_t ROUT   = 27'(1) << 3;
    localparam vec_t BAOUT  = 27'(1) << 4;
    localparam vec_t COUT   = 27'(1) << 5;
    localparam vec_t PCIN   = 27'(1) << 6;
    localparam vec_t MARIN  = 27'(1) << 7;
    localparam vec_t MDRIN  = 27'(1) << 8;
    localparam vec_t IRIN   = 27'(1) << 9;
    localparam vec_t YIN    = 27'(1) << 10;
    localparam vec_t ZIN    = 27'(1) << 11;
    localparam vec_t RIN    = 27'(1) << 12;
    localparam vec_t CONIN  = 27'(1) << 13;
    localparam vec_t OUTIN  = 27'(1) << 14;
    localparam vec_t GRA    = 27'(1) << 15;
    localparam vec_t GRB    = 27'(1) << 16;
    localparam vec_t GRC    = 27'(1) << 17;
    localparam vec_t READ   = 27'(1) << 18;
    localparam vec_t WRITE  = 27'(1) << 19;
    localparam vec_t RUN    = 27'(1) << 20;
    localparam vec_t ILL    = 27'(1) << 26;

    function automatic vec_t alu(input int code);
        return vec_t'(code) << 21;
    endfunction

    localparam vec_t F0 = RUN | PCOUT | MARIN | ZIN | (27'd12 << 21);
    localparam vec_t F1 = RUN | ZLOW | PCIN | READ | MDRIN;
    localparam vec_t F2 = RUN | MDROUT | IRIN;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic PCout, Zlowout, MDRout, Rout, BAout, Cout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn;
    logic Gra, Grb, Grc, Read, Write, Run;
    logic [4:0] ALU_Control;
    logic ill;

    datapath_control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
        .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Rin(Rin), .CONin(CONin),
        .OutportIn(OutportIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Read(Read), .Write(Write),
        .ALU_Control(ALU_Control),
`ifdef CONTROL_ILLEGAL_TRAP_EN
        .Illegal(ill),
`endif
        .Run(Run)
    );

`ifndef CONTROL_ILLEGAL_TRAP_EN
    assign ill = 1'b0;
`endif

    vec_t got;
    assign got = {ill, ALU_Control, Run, Write, Read, Grc, Grb, Gra,
                  OutportIn, CONin, Rin, Zin, Yin, IRin, MDRin, MARin,
                  PCin, Cout, BAout, Rout, MDRout, Zlowout, PCout};

    always #5 clk = ~clk;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s: got=%h exp=%h", e.tag, got, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "timeout");
    end

    task automatic expect1(input vec_t v, input string tag);
        ent_t e;
        e.v = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 in T0; drives IR and queues one entry per step.
    task automatic run_instr(input logic [31:0] ir, input logic con,
                             input int stop_at, input vec_t seq[$],
                             input string tag);
        IR = ir;
        CON_FF = con;
        for (int i = 0; i < seq.size(); i++)
            expect1(seq[i], $sformatf("%s_s%0d", tag, i));
        for (int k = 0; k < seq.size(); k++) begin
            if (k == stop_at) Stop = 1'b1;
            tick();
        end
    endtask

    task automatic idle(input int n, input vec_t v, input string tag);
        for (int k = 0; k < n; k++) begin
            expect1(v, $sformatf("%s_%0d", tag, k));
            tick();
        end
    endtask

    task automatic clr_pulse(input string tag);
        clr = 1'b1;
        expect1('0, {tag, "_hi"});
        tick();
        clr = 1'b0;
        expect1('0, {tag, "_lo"});
        tick();
    endtask

    vec_t s[$];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        clr_pulse("reset");

        s = '{F0, F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN|alu(2),
              RUN|ZLOW|GRA|RIN};
        run_instr(32'h08800075, 1'b0, -1, s, "ldi");

        s = '{F0, F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN|alu(2),
              RUN|ZLOW|MARIN, RUN|GRA|ROUT|MDRIN, RUN|WRITE};
        run_instr(32'h10800010, 1'b0, -1, s, "st");

        s = '{F0, F1, F2, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN,
              RUN|COUT|ZIN|alu(2), RUN};
        run_instr(32'h60800004, 1'b0, -1, s, "br_nt");

        s = '{F0, F1, F2, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN,
              RUN|COUT|ZIN|alu(2), RUN|ZLOW|PCIN};
        run_instr(32'h60800004, 1'b1, -1, s, "br_t");

        s = '{F0, F1, F2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN|alu(2),
              RUN|ZLOW|MARIN, RUN|READ|MDRIN, RUN|MDROUT|GRA|RIN};
        run_instr(32'h00800000, 1'b0, -1, s, "ld");

        s = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|COUT|ZIN|alu(5),
              RUN|ZLOW|GRA|RIN};
        run_instr(32'h50000000, 1'b0, -1, s, "andi");

        s = '{F0, F1, F2, RUN|GRA|ROUT|OUTIN};
        run_instr(32'h68000000, 1'b0, -1, s, "out");

        s = '{F0, F1, F2};
        run_instr(32'h70000000, 1'b0, -1, s, "nop");

        s = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN|alu(4),
              RUN|ZLOW|GRA|RIN};
        run_instr(32'h20000000, 1'b0, -1, s, "sub");

        s = '{F0, F1, F2, RUN|GRB|ROUT|YIN};
        run_instr(32'h18000000, 1'b0, -1, s, "add_cut");
        clr_pulse("clr_mid");

        s = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN|alu(3),
              RUN|ZLOW|GRA|RIN};
        run_instr(32'h18000000, 1'b0, 4, s, "add_stop");
        idle(2, '0, "halt_stop");
        Stop = 1'b0;
        idle(2, '0, "halt_hold");
        clr_pulse("halt_exit");

        s = '{F0, F1, F2};
        run_instr(32'hF8000000, 1'b0, -1, s, "illop");
`ifdef CONTROL_ILLEGAL_TRAP_EN
        idle(3, ILL, "ill_halt");
        clr_pulse("ill_clr");
`endif
        s = '{F0, F1, F2};
        run_instr(32'h70000000, 1'b0, -1, s, "nop_end");

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
